digit_scan_controller: RTL

DIGIT_SCAN_CONTROLLER -- requirements
Module: digit_scan_controller

---
 rtl/digit_scan_controller.sv | 108 ++++++++++
 1 files changed

// File: rtl/digit_scan_controller.sv
// Time-multiplexed scan of four display digits: each enabled digit is shown
// for DIV cycles, followed by BLANK dark cycles, cycling through digit_mask.
module digit_scan_controller #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [3:0]  digit_mask,
  input  logic [15:0] digits,
  output logic [1:0]  w,
  output logic        En,
  output logic [3:0]  nibble,
  output logic        frame_done
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state;
  logic [DW-1:0] dwell;
  logic [BW-1:0] gap;
  logic          at_advance_c;
  logic [1:0]    first_sel_c;
  logic [1:0]    adv_sel_c;

  // Next set mask bit searching upward from cur+1, wrapping; cur itself last.
  function automatic logic [1:0] next_sel(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] sel;
    logic [1:0] idx;
    sel = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (mask[idx]) sel = idx;
    end
    return sel;
  endfunction

  function automatic logic [3:0] nib_of(input logic [15:0] d, input logic [1:0] sel);
    return d[{sel, 2'b00} +: 4];
  endfunction

  assign first_sel_c  = next_sel(digit_mask, 2'd3);
  assign adv_sel_c    = next_sel(digit_mask, w);
  assign at_advance_c = ((state == SHOW) && (dwell == '0) && (BLANK == 0)) ||
                        ((state == GAP) && (gap == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      w          <= 2'd0;
      En         <= 1'b0;
      nibble     <= 4'd0;
      frame_done <= 1'b0;
      dwell      <= '0;
      gap        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!run) begin
        state  <= IDLE;
        w      <= 2'd0;
        En     <= 1'b0;
        nibble <= 4'd0;
        dwell  <= '0;
        gap    <= '0;
      end else if (state == IDLE) begin
        if (digit_mask != 4'd0) begin
          state  <= SHOW;
          w      <= first_sel_c;
          En     <= 1'b1;
          nibble <= nib_of(digits, first_sel_c);
          dwell  <= DW'(DIV - 1);
        end
      end else if (at_advance_c) begin
        // Mask is only looked at here, so a mid-visit change never truncates a visit.
        if (digit_mask == 4'd0) begin
          state  <= IDLE;
          w      <= 2'd0;
          En     <= 1'b0;
          nibble <= 4'd0;
          dwell  <= '0;
          gap    <= '0;
        end else begin
          state      <= SHOW;
          w          <= adv_sel_c;
          En         <= 1'b1;
          nibble     <= nib_of(digits, adv_sel_c);
          dwell      <= DW'(DIV - 1);
          frame_done <= (adv_sel_c <= w);
        end
      end else if (state == SHOW) begin
        if (dwell != '0) begin
          dwell <= dwell - DW'(1);
        end else begin
          state <= GAP;
          En    <= 1'b0;
          gap   <= BW'(BLANK - 1);
        end
      end else begin
        gap <= gap - BW'(1);
      end
    end
  end

endmodule
